// File: rtl/mem_port_arbiter_if.sv
// Bundles the request, memory-side and completion signals of the memory port arbiter.
// Ports: IF request/address; D request/write/address/write data; memory done/read data;
//        memory select/start/write/address/write data; IF/D done pulses, read data, error.
// master = requesters plus memory (the environment); slave = the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_sel;
  logic              mem_start;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              if_done;
  logic              d_done;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_done, mem_rdata,
    input  mem_sel, mem_start, mem_wr, mem_addr, mem_wdata, if_done, d_done, rdata, err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_done, mem_rdata,
    output mem_sel, mem_start, mem_wr, mem_addr, mem_wdata, if_done, d_done, rdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch (IF) and data stage (D).
// Ports: clk, rst_n (async active-low), bus (slave modport: requests, memory side, done/rdata/err).
// Latency: request in IDLE -> mem_start next cycle; mem_done -> *_done next cycle; one IDLE bubble
// between grants. D wins ties unless it has taken STARVE grants in a row while IF waited.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int STARVE  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
  // Abort fires from the last allowed grant cycle so the done pulse lands
  // TIMEOUT cycles after the start strobe.
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, G_IF, G_D} state_t;

  state_t            state_q,  state_d;
  logic              sel_q,    sel_d;
  logic              start_q,  start_d;
  logic              wr_q,     wr_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              err_q,    err_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     tmo_q,    tmo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      start_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      starve_q  <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      start_q   <= start_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_done_q <= if_done_d;
      d_done_q  <= d_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    start_d   = 1'b0;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_done_d = 1'b0;
    d_done_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    starve_d  = starve_q;
    tmo_d     = tmo_q;

    unique case (state_q)
      IDLE: begin
        // mem_done is ignored here: no owner, so no completion pulse.
        if (bus.d_req && !(bus.if_req && starve_q == STARVE_MAX)) begin
          state_d = G_D;
          start_d = 1'b1;
          sel_d   = 1'b1;
          wr_d    = bus.d_wr;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          tmo_d   = '0;
          // Count D wins only while IF is actually waiting.
          if (!bus.if_req)                starve_d = '0;
          else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
        end else if (bus.if_req) begin
          state_d  = G_IF;
          start_d  = 1'b1;
          sel_d    = 1'b0;
          wr_d     = 1'b0;
          addr_d   = bus.if_addr;
          tmo_d    = '0;
          starve_d = '0;
        end
      end
      G_IF, G_D: begin
        // Completion goes to the current owner even if its request was dropped.
        if (bus.mem_done) begin
          state_d   = IDLE;
          if_done_d = (state_q == G_IF);
          d_done_d  = (state_q == G_D);
          if (!wr_q) rdata_d = bus.mem_rdata;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = IDLE;
          if_done_d = (state_q == G_IF);
          d_done_d  = (state_q == G_D);
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_sel   = sel_q;
  assign bus.mem_start = start_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: memory-access and completion expectations are queued
// by the stimulus; a negedge monitor pops and compares whenever mem_start or a done pulse appears.
// A behavioural memory answers each start after resp_lat cycles (or never when resp_lat < 0).
module tb_mem_port_arbiter;

  typedef struct {
    logic        sel;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  typedef struct {
    logic        is_d;
    logic        err;
    logic [15:0] rdata;
    int          lat;   // cycles from mem_start to done pulse
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE(3), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  int          resp_lat  = -1;
  logic [15:0] resp_data = '0;
  logic        stray     = 1'b0;

  int cyc       = 0;
  int start_cyc = 0;
  int n_done    = 0;
  int n_start   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: mem_done and mem_rdata are only ever driven here.
  initial begin
    int cnt;
    cnt = -1;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_done = stray;
      if (!rst_n) cnt = -1;
      else if (bus.mem_start) cnt = resp_lat;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = resp_data;
          cnt = -1;
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (bus.mem_start) begin
      n_start++;
      start_cyc = cyc;
      if (acc_q.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        acc_t e;
        e = acc_q.pop_front();
        chk("acc_sel",  bus.mem_sel,  e.sel);
        chk("acc_wr",   bus.mem_wr,   e.wr);
        chk("acc_addr", bus.mem_addr, e.addr);
        if (e.wr) chk("acc_wdata", bus.mem_wdata, e.wdata);
      end
    end
    if (bus.err && !(bus.if_done || bus.d_done)) chk("err_without_done", 1, 0);
    if (bus.if_done || bus.d_done) begin
      n_done++;
      if (rsp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rsp_owner", {bus.if_done, bus.d_done}, {~r.is_d, r.is_d});
        chk("rsp_err",   bus.err,   r.err);
        chk("rsp_rdata", bus.rdata, r.rdata);
        chk("rsp_lat",   cyc - start_cyc, r.lat);
      end
    end
  end

  task automatic push_acc(input logic sel, input logic wr, input logic [15:0] a, input logic [15:0] w);
    acc_t e;
    e.sel = sel; e.wr = wr; e.addr = a; e.wdata = w;
    acc_q.push_back(e);
  endtask

  task automatic push_rsp(input logic is_d, input logic er, input logic [15:0] rd, input int lat);
    rsp_t r;
    r.is_d = is_d; r.err = er; r.rdata = rd; r.lat = lat;
    rsp_q.push_back(r);
  endtask

  // Returns in the cycle the n-th done pulse is visible so callers can drop requests there.
  task automatic wait_done(input int n, input int max, input string name);
    int got;
    got = 0;
    for (int i = 0; i < max && got < n; i++) begin
      @(posedge clk); #1;
      if (bus.if_done || bus.d_done) got++;
    end
    chk(name, got, n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    int snap_d, snap_s, waited;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_wr = 0;
    bus.d_addr = '0; bus.d_wdata = '0;

    // Reset state.
    #12;
    chk("reset_outputs", {bus.mem_sel, bus.mem_start, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                          bus.if_done, bus.d_done, bus.rdata, bus.err}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // IF read: start one cycle after request, mem_done 3 later, if_done one after that.
    resp_lat = 3; resp_data = 16'hBEEF;
    push_acc(0, 0, 16'h0040, 16'h0000);
    push_rsp(0, 0, 16'hBEEF, 4);
    bus.if_req = 1; bus.if_addr = 16'h0040;
    @(posedge clk); #1;
    chk("if_start_n1", {bus.mem_start, bus.mem_sel}, 2'b10);
    wait_done(1, 20, "if_read_done");
    bus.if_req = 0;
    idle(2);

    // D write: rdata must keep 0xBEEF even though memory presents 0xDEAD.
    resp_lat = 2; resp_data = 16'hDEAD;
    push_acc(1, 1, 16'h1000, 16'h1234);
    push_rsp(1, 0, 16'hBEEF, 3);
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h1000; bus.d_wdata = 16'h1234;
    wait_done(1, 20, "d_write_done");
    bus.d_req = 0; bus.d_wr = 0;
    idle(2);

    // Contention: D,D,D,IF,D,D,D,IF with mem_done one cycle after each start.
    resp_lat = 1; resp_data = 16'h5A5A;
    bus.if_addr = 16'h0100; bus.d_addr = 16'h0200;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) begin
        push_acc(0, 0, 16'h0100, 16'h0000);
        push_rsp(0, 0, 16'h5A5A, 2);
      end else begin
        push_acc(1, 0, 16'h0200, 16'h0000);
        push_rsp(1, 0, 16'h5A5A, 2);
      end
    end
    bus.if_req = 1; bus.d_req = 1;
    wait_done(8, 60, "contention_done");
    bus.if_req = 0; bus.d_req = 0;
    idle(2);

    // Timeout: no mem_done; abort pulse at grant cycle 16 with rdata unchanged.
    resp_lat = -1; resp_data = 16'h7777;
    push_acc(1, 0, 16'h2000, 16'h0000);
    push_rsp(1, 1, 16'h5A5A, 15);
    bus.d_req = 1; bus.d_addr = 16'h2000;
    wait_done(1, 40, "timeout_done");
    bus.d_req = 0;
    idle(2);

    // Stray mem_done while idle: no start, done or err.
    snap_d = n_done; snap_s = n_start;
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    idle(4);
    chk("stray_no_done",  n_done,  snap_d);
    chk("stray_no_start", n_start, snap_s);

    // Async reset mid-grant: outputs clear before the next clock edge.
    push_acc(1, 0, 16'h3000, 16'h0000);
    bus.d_req = 1; bus.d_addr = 16'h3000;
    waited = 0;
    while (!bus.mem_start && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("rst_grant_started", bus.mem_start, 1'b1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_grant_outputs", {bus.mem_sel, bus.mem_start, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                                  bus.if_done, bus.d_done, bus.rdata, bus.err}, 0);
    bus.d_req = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Arbiter recovers after reset: plain IF read.
    resp_lat = 2; resp_data = 16'h0F0F;
    push_acc(0, 0, 16'h0044, 16'h0000);
    push_rsp(0, 0, 16'h0F0F, 3);
    bus.if_req = 1; bus.if_addr = 16'h0044;
    wait_done(1, 20, "post_reset_done");
    bus.if_req = 0;
    idle(3);

    chk("acc_queue_empty", acc_q.size(), 0);
    chk("rsp_queue_empty", rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
